// File: rtl/mcl_fsb_pkg.sv
// Shared FSB bridge types and widths.
// Packet shape and credit counter width.
package mcl_fsb_pkg;

  localparam int fsb_width_gp = 80;
  localparam int credit_width_gp = 8;

  typedef logic [fsb_width_gp-1:0] fsb_pkt_s;
  typedef logic [credit_width_gp-1:0] credit_t;

endpackage

// File: rtl/mcl_fsb_fifo.sv
// Registered FIFO, no bypass, valid/yumi output side.
// Ready comes from the registered full state only.
module mcl_fsb_fifo
  import mcl_fsb_pkg::*;
#(
  parameter int width_p = fsb_width_gp,
  parameter int els_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int aw = $clog2(els_p);

  logic [aw:0]        wr_ptr;
  logic [aw:0]        rd_ptr;
  logic [width_p-1:0] mem [els_p];
  logic               full;
  logic               empty;
  logic               enq;
  logic               deq;

  // Occupancy flags from the extra wrap bit.
  always_comb begin
    full = (wr_ptr[aw] != rd_ptr[aw])
        && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    empty = (wr_ptr == rd_ptr);
    ready_o = !full && reset_n_i;
    v_o = !empty;
    enq = v_i && ready_o;
    deq = yumi_i && !empty;
    data_o = mem[rd_ptr[aw-1:0]];
  end

  // Pointer advance on accepted pushes and pops.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage; cleared on reset so old packets never resurface.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem[i] <= '0;
    end else if (enq) begin
      mem[wr_ptr[aw-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/mcl_fsb_credit_bridge.sv
// Per-slot FSB bridge: credited TX path, valid/yumi RX path.
// Holds the credit counter and packet status counters.
module mcl_fsb_credit_bridge
  import mcl_fsb_pkg::*;
#(
  parameter int fsb_width_p = fsb_width_gp,
  parameter int tx_els_p = 4,
  parameter int rx_els_p = 4,
  parameter int credits_p = 8,
  parameter int cnt_width_p = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       fsb_v_i,
  input  logic [fsb_width_p-1:0]     fsb_data_i,
  output logic                       fsb_ready_o,
  output logic                       fsb_v_o,
  output logic [fsb_width_p-1:0]     fsb_data_o,
  input  logic                       fsb_yumi_i,
  output logic                       dev_v_o,
  output logic [fsb_width_p-1:0]     dev_data_o,
  input  logic                       dev_credit_i,
  input  logic                       dev_v_i,
  input  logic [fsb_width_p-1:0]     dev_data_i,
  output logic                       dev_ready_o,
  output logic [credit_width_gp-1:0] credit_o,
  output logic [cnt_width_p-1:0]     tx_cnt_o,
  output logic [cnt_width_p-1:0]     rx_cnt_o,
  output logic                       credit_err_o
);

  localparam credit_t cred_max = credit_width_gp'(credits_p);

  logic    tx_v;
  logic    send;
  logic    rx_pop;
  credit_t credit_r;

  mcl_fsb_fifo #(
    .width_p(fsb_width_p),
    .els_p  (tx_els_p)
  ) tx_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (fsb_v_i),
    .ready_o  (fsb_ready_o),
    .data_i   (fsb_data_i),
    .v_o      (tx_v),
    .data_o   (dev_data_o),
    .yumi_i   (send)
  );

  mcl_fsb_fifo #(
    .width_p(fsb_width_p),
    .els_p  (rx_els_p)
  ) rx_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (dev_v_i),
    .ready_o  (dev_ready_o),
    .data_i   (dev_data_i),
    .v_o      (fsb_v_o),
    .data_o   (fsb_data_o),
    .yumi_i   (fsb_yumi_i)
  );

  // The device cannot stall, so any offered packet is a send.
  always_comb begin
    send = tx_v && (credit_r != '0);
    dev_v_o = send;
    rx_pop = fsb_yumi_i && fsb_v_o;
    credit_o = credit_r;
  end

  // Credit counter; an excess return saturates and flags an error.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_r <= cred_max;
      credit_err_o <= 1'b0;
    end else if (send && !dev_credit_i) begin
      credit_r <= credit_r - 1'b1;
    end else if (!send && dev_credit_i) begin
      if (credit_r == cred_max) credit_err_o <= 1'b1;
      else credit_r <= credit_r + 1'b1;
    end
  end

  // Free-running packet counters, wrapping naturally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_cnt_o <= '0;
      rx_cnt_o <= '0;
    end else begin
      if (send) tx_cnt_o <= tx_cnt_o + 1'b1;
      if (rx_pop) rx_cnt_o <= rx_cnt_o + 1'b1;
    end
  end

endmodule
